hdc_classify_ctrl: RTL
======================

// Module: hdc_classify_ctrl
// PURPOSE
// Sequencer for the HDC spam/ham classification datapath. Accepts a message as a byte
// stream and tokenises each byte to an item-memory symbol. Schedules the chunked passes
// over the DIM-wide vectors: accumulate, threshold, then dot product against the ham and
// spam class vectors. Makes the final decision using a norm-weighted compare.
// The datapath (item memory, accumulator RAM, class memories, dot-product units) is external.
// PARAMETERS
// DIM        10000  hypervector dimension
// CHUNK      16     elements processed per cycle; NCHUNK = ceil(DIM/CHUNK)
// MAX_LENGTH 200    max characters accumulated per message
// DOT_W      32     signed width of dot-product inputs
// CW         clog2(NCHUNK)  chunk index width (derived, localparam)
// PORTS
// clk         in   1      clock, rising edge
// reset       in   1      asynchronous, active-low reset
// char_valid  in   1      byte on char_data valid
// char_ready  out  1      controller accepts byte this cycle
// char_data   in   8      ASCII byte
// char_last   in   1      byte is final character of message
// norm_ham    in   16     unsigned norm of ham class vector (static)
// norm_spam   in   16     unsigned norm of spam class vector (static)
// mem_rd      out  1      synchronous read strobe to active memory (1-cycle read latency)
// mem_chunk   out  CW     chunk address for mem_rd
// im_sym      out  6      item-memory symbol (0..36) for current ACCUM pass
// work_chunk  out  CW     mem_chunk delayed 1 cycle; qualifies acc_en/thr_en/dot_en
// acc_clr     out  1      clear accumulator RAM and element sum
// acc_en      out  1      add item-memory chunk into accumulator chunk work_chunk
// thr_en      out  1      binarise accumulator chunk work_chunk against the average
// dot_clr     out  1      clear both dot-product accumulators
// dot_en      out  1      accumulate msg·ham and msg·spam for chunk work_chunk
// dot_ham     in   DOT_W  signed dot(msg, ham); final 1 cycle after last dot_en
// dot_spam    in   DOT_W  signed dot(msg, spam)
// result      out  2      signed: 0 ham, 1 spam, 2'b11 (-1) tie
// result_valid out 1      1-cycle pulse when result updates
// overflow    out  1      message exceeded MAX_LENGTH; valid with result_valid
// busy        out  1      high in every state except IDLE
// BEHAVIOUR
// - Reset (async, reset=0): state IDLE; all outputs 0; char count 0. Mid-operation
//   reset abandons the message; a new message starts from IDLE after release.
// - Tokenise: 'A'-'Z'/'a'-'z' -> 11..36; '0'-'9' -> 1..10; any other byte -> 0.
// - States: IDLE, ACCUM, NEXT, THRESH, DOT, DECIDE.
// - IDLE/NEXT: char_ready=1. Handshake is char_valid&char_ready.
//   - On accept in IDLE, acc_clr pulses in that cycle and count is reset.
//   - Accepted byte -> latch im_sym, last flag, count+1, go to ACCUM.
//   - If count already = MAX_LENGTH: set overflow, skip ACCUM. Go to THRESH if last, else stay NEXT.
// - ACCUM/THRESH/DOT passes: each is NCHUNK+1 cycles.
//   - Cycles 0..NCHUNK-1: mem_rd=1, mem_chunk=0..NCHUNK-1.
//   - Cycles 1..NCHUNK: phase enable=1 with work_chunk = previous mem_chunk.
//   - char_ready=0 throughout.
// - ACCUM exit: to THRESH if latched last, else NEXT.
// - THRESH exit: to DOT; dot_clr pulses in the first DOT cycle.
// - DOT exit: to DECIDE; the extra cycle lets dot_ham/dot_spam settle.
// - DECIDE (1 cycle): compute signed 49-bit P_h = dot_ham*norm_spam and P_s = dot_spam*norm_ham.
//   - result = 0 if P_h > P_s; 1 if P_h < P_s; 2'b11 if equal.
//   - result_valid pulses; go to IDLE. result/overflow hold until next decision.
// - Latency: last char accept -> result_valid = (NCHUNK+1)*(ACCUM?1:0) + 2*(NCHUNK+1) + 1 cycles.
// - char_valid during busy passes is ignored (not accepted, no data loss upstream).
// - Zero-length message is impossible: the message ends on the char_last byte.
// TESTING (DIM=64, CHUNK=16 -> NCHUNK=4, MAX_LENGTH=4)
// - Reset held mid-ACCUM, then released -> all outputs 0, busy=0, char_ready=1 next cycle.
// - Bytes "A","z","5","#" (last) -> im_sym 11,36,6,0; 4 ACCUM passes of 5 cycles each;
//   acc_clr only with "A"; mem_chunk 0,1,2,3.
// - Single byte 'x' last, dot_ham=100, dot_spam=50, norms 10/10 -> result=0 after 5+5+5+1 cycles.
// - dot_ham=30, dot_spam=40, norm_ham=10, norm_spam=12 -> P_h=360 < P_s=400 -> result=1.
// - dot_ham=-20, dot_spam=-20, equal norms -> result=2'b11, result_valid pulse.
// - 6 bytes, MAX_LENGTH=4 -> bytes 5-6 accepted without ACCUM; overflow=1 with result_valid.

Source files
------------

// File: rtl/hdc_classify_ctrl.sv
// rtl/hdc_classify_ctrl.sv - sequencer for the HDC spam/ham classification datapath
//
// Accepts a message one byte at a time, turns each byte into an item-memory
// symbol and runs the chunked passes over the external datapath:
// one ACCUM pass per byte, then one THRESH pass and one DOT pass per message.
// The last step is a norm-weighted compare of the two dot products.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   char_valid/char_ready      byte handshake; char_data byte, char_last ends message
//   norm_ham, norm_spam        static unsigned class-vector norms
//   mem_rd, mem_chunk          read strobe and chunk address to the active memory
//   im_sym                     item-memory symbol of the byte being accumulated
//   work_chunk                 mem_chunk one cycle later; qualifies acc_en/thr_en/dot_en
//   acc_clr                    clear accumulator, same cycle as the first byte's accept
//   acc_en, thr_en, dot_en     per-chunk phase enables
//   dot_clr                    clear both dot-product accumulators
//   dot_ham, dot_spam          signed dot products from the datapath
//   result, result_valid       0 ham, 1 spam, 2'b11 tie; one-cycle pulse on update
//   overflow                   message was longer than MAX_LENGTH
//   busy                       controller is not idle
module hdc_classify_ctrl #(
    parameter  int DIM        = 10000,
    parameter  int CHUNK      = 16,
    parameter  int MAX_LENGTH = 200,
    parameter  int DOT_W      = 32,
    localparam int NCHUNK     = (DIM + CHUNK - 1) / CHUNK,
    localparam int CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    output logic             char_ready,
    input  logic [7:0]       char_data,
    input  logic             char_last,
    input  logic [15:0]      norm_ham,
    input  logic [15:0]      norm_spam,
    output logic             mem_rd,
    output logic [CW-1:0]    mem_chunk,
    output logic [5:0]       im_sym,
    output logic [CW-1:0]    work_chunk,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             thr_en,
    output logic             dot_clr,
    output logic             dot_en,
    input  logic [DOT_W-1:0] dot_ham,
    input  logic [DOT_W-1:0] dot_spam,
    output logic [1:0]       result,
    output logic             result_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int NW = $clog2(MAX_LENGTH + 1);
    localparam int PW = DOT_W + 17;
    localparam logic [CW:0] CNT_LAST = (CW + 1)'(NCHUNK);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_NEXT   = 3'd2,
        S_THRESH = 3'd3,
        S_DOT    = 3'd4,
        S_DECIDE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW:0]   cnt_q, cnt_d;          // cycle index inside a pass, 0..NCHUNK
    logic [NW-1:0] count_q, count_d;      // characters accumulated so far
    logic          last_q, last_d;
    logic          ovf_q, ovf_d;          // overflow of the message in progress
    logic          char_ready_q, char_ready_d;
    logic          mem_rd_q, mem_rd_d;
    logic [CW-1:0] mem_chunk_q, mem_chunk_d;
    logic [CW-1:0] work_chunk_q, work_chunk_d;
    logic [5:0]    im_sym_q, im_sym_d;
    logic          acc_en_q, acc_en_d;
    logic          thr_en_q, thr_en_d;
    logic          dot_en_q, dot_en_d;
    logic          dot_clr_q, dot_clr_d;
    logic [1:0]    result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          overflow_q, overflow_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          pass_d;
    logic signed [PW-1:0] ham_ext, spam_ext, nham_ext, nspam_ext;
    logic signed [PW-1:0] p_h, p_s;

    function automatic logic [5:0] tokenise(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5a) return 6'(c - 8'h41 + 8'd11);
        if (c >= 8'h61 && c <= 8'h7a) return 6'(c - 8'h61 + 8'd11);
        if (c >= 8'h30 && c <= 8'h39) return 6'(c - 8'h30 + 8'd1);
        return 6'd0;
    endfunction

    assign accept = char_valid & char_ready_q;

    // The clear must coincide with the accept of the first byte, so it is
    // decoded from the handshake rather than registered.
    assign acc_clr = accept & (state_q == S_IDLE);

    // Cross products in a width that holds any DOT_W x 16-bit product exactly.
    assign ham_ext   = {{(PW - DOT_W){dot_ham[DOT_W-1]}}, dot_ham};
    assign spam_ext  = {{(PW - DOT_W){dot_spam[DOT_W-1]}}, dot_spam};
    assign nham_ext  = {{(PW - 16){1'b0}}, norm_ham};
    assign nspam_ext = {{(PW - 16){1'b0}}, norm_spam};
    assign p_h       = ham_ext * nspam_ext;
    assign p_s       = spam_ext * nham_ext;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        count_d        = count_q;
        last_d         = last_q;
        ovf_d          = ovf_q;
        im_sym_d       = im_sym_q;
        result_d       = result_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_ACCUM;
                    cnt_d    = '0;
                    count_d  = NW'(1);
                    ovf_d    = 1'b0;
                    last_d   = char_last;
                    im_sym_d = tokenise(char_data);
                end
            end
            S_NEXT: begin
                if (accept) begin
                    last_d = char_last;
                    cnt_d  = '0;
                    if (count_q == NW'(MAX_LENGTH)) begin
                        // Excess characters are consumed but never accumulated.
                        ovf_d   = 1'b1;
                        state_d = char_last ? S_THRESH : S_NEXT;
                    end else begin
                        count_d  = count_q + NW'(1);
                        im_sym_d = tokenise(char_data);
                        state_d  = S_ACCUM;
                    end
                end
            end
            S_ACCUM, S_THRESH, S_DOT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (state_q == S_ACCUM)       state_d = last_q ? S_THRESH : S_NEXT;
                    else if (state_q == S_THRESH) state_d = S_DOT;
                    else                          state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q + (CW + 1)'(1);
                end
            end
            S_DECIDE: begin
                result_valid_d = 1'b1;
                overflow_d     = ovf_q;
                if (p_h > p_s)      result_d = 2'b00;
                else if (p_h < p_s) result_d = 2'b01;
                else                result_d = 2'b11;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reads run on pass cycles 0..NCHUNK-1; the enable follows one cycle
        // later, so the final pass cycle only drains the read pipeline.
        pass_d       = (state_d == S_ACCUM) || (state_d == S_THRESH) || (state_d == S_DOT);
        mem_rd_d     = pass_d && (cnt_d != CNT_LAST);
        mem_chunk_d  = mem_rd_d ? cnt_d[CW-1:0] : '0;
        work_chunk_d = mem_chunk_q;
        acc_en_d     = mem_rd_q && (state_q == S_ACCUM);
        thr_en_d     = mem_rd_q && (state_q == S_THRESH);
        dot_en_d     = mem_rd_q && (state_q == S_DOT);
        dot_clr_d    = (state_d == S_DOT) && (cnt_d == '0);
        char_ready_d = (state_d == S_IDLE) || (state_d == S_NEXT);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            count_q        <= '0;
            last_q         <= 1'b0;
            ovf_q          <= 1'b0;
            char_ready_q   <= 1'b0;
            mem_rd_q       <= 1'b0;
            mem_chunk_q    <= '0;
            work_chunk_q   <= '0;
            im_sym_q       <= '0;
            acc_en_q       <= 1'b0;
            thr_en_q       <= 1'b0;
            dot_en_q       <= 1'b0;
            dot_clr_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            count_q        <= count_d;
            last_q         <= last_d;
            ovf_q          <= ovf_d;
            char_ready_q   <= char_ready_d;
            mem_rd_q       <= mem_rd_d;
            mem_chunk_q    <= mem_chunk_d;
            work_chunk_q   <= work_chunk_d;
            im_sym_q       <= im_sym_d;
            acc_en_q       <= acc_en_d;
            thr_en_q       <= thr_en_d;
            dot_en_q       <= dot_en_d;
            dot_clr_q      <= dot_clr_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            busy_q         <= busy_d;
        end
    end

    assign char_ready   = char_ready_q;
    assign mem_rd       = mem_rd_q;
    assign mem_chunk    = mem_chunk_q;
    assign work_chunk   = work_chunk_q;
    assign im_sym       = im_sym_q;
    assign acc_en       = acc_en_q;
    assign thr_en       = thr_en_q;
    assign dot_en       = dot_en_q;
    assign dot_clr      = dot_clr_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;

endmodule
